// File: rtl/axis_token_bucket_shaper_if.sv
// AXI-Stream bus bundle used on both sides of the token bucket shaper.
// Carries valid/ready handshake plus data, byte enables and end-of-packet.
//   master modport : drives tvalid/tdata/tkeep/tlast, samples tready
//   slave modport  : samples tvalid/tdata/tkeep/tlast, drives tready
interface axis_token_bucket_shaper_if #(
  parameter int AXIS_WIDTH      = 64,
  parameter int AXIS_KEEP_WIDTH = AXIS_WIDTH / 8
);

  logic                       tvalid;
  logic                       tready;
  logic [AXIS_WIDTH-1:0]      tdata;
  logic [AXIS_KEEP_WIDTH-1:0] tkeep;
  logic                       tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);

endinterface

// File: rtl/axis_token_bucket_shaper.sv
// Ingress rate shaper: admits whole AXI-Stream packets according to a
// byte-granular token bucket and passes admitted packets through with zero
// latency. Gating is only ever applied at packet boundaries.
// Ports:
//   clk_i, rst_i   : stream clock, asynchronous active-high reset
//   s_axis         : upstream stream (slave side)
//   m_axis         : downstream stream (master side), data/keep/last = s_axis
//   cfg_enable_i   : 0 = bypass, bucket held full
//   cfg_rate_i     : refill per cycle, UQ(TOKEN_WIDTH.FRAC_BITS) bytes
//   cfg_burst_i    : bucket ceiling in bytes
//   pkt_cnt_o      : number of tlast beats transferred
//   stall_cnt_o    : cycles where upstream offered data but the shaper held it off
module axis_token_bucket_shaper #(
  parameter int AXIS_WIDTH      = 64,
  parameter int AXIS_KEEP_WIDTH = AXIS_WIDTH / 8,
  parameter int TOKEN_WIDTH     = 24,
  parameter int FRAC_BITS       = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  axis_token_bucket_shaper_if.slave        s_axis,
  axis_token_bucket_shaper_if.master       m_axis,
  input  logic                             cfg_enable_i,
  input  logic [TOKEN_WIDTH+FRAC_BITS-1:0] cfg_rate_i,
  input  logic [TOKEN_WIDTH-1:0]           cfg_burst_i,
  output logic [31:0]                      pkt_cnt_o,
  output logic [31:0]                      stall_cnt_o
);

  // Bucket width includes a sign bit; the sum is two bits wider so refill plus
  // a full bucket cannot overflow before saturation.
  localparam int BW  = TOKEN_WIDTH + FRAC_BITS + 1;
  localparam int SW  = BW + 2;
  localparam int KCW = $clog2(AXIS_KEEP_WIDTH + 1);

  typedef enum logic {IDLE = 1'b0, PASS = 1'b1} state_t;

  state_t                state;
  logic signed [BW-1:0]  bucket;
  logic signed [BW-1:0]  bucket_next;
  logic signed [SW-1:0]  sum;
  logic signed [SW-1:0]  ceiling;
  logic signed [SW-1:0]  floor_val;
  logic signed [SW-1:0]  cost;
  logic [KCW-1:0]        keep_count;
  logic                  in_pkt;
  logic                  allow;
  logic                  beat;

  // Once a packet is admitted it is never held off; between packets a
  // non-negative bucket admits the next one. Reset blocks both directions.
  assign in_pkt = (state == PASS);
  assign allow  = ~rst_i & (in_pkt | ~cfg_enable_i | ~bucket[BW-1]);
  assign beat   = s_axis.tvalid & m_axis.tready & allow;

  assign m_axis.tvalid = s_axis.tvalid & allow;
  assign s_axis.tready = m_axis.tready & allow;
  assign m_axis.tdata  = s_axis.tdata;
  assign m_axis.tkeep  = s_axis.tkeep;
  assign m_axis.tlast  = s_axis.tlast;

  // Number of valid bytes in the current beat.
  always_comb begin
    keep_count = '0;
    for (int i = 0; i < AXIS_KEEP_WIDTH; i++) begin
      keep_count = keep_count + KCW'(s_axis.tkeep[i]);
    end
  end

  // Refill and consumption are combined first, then clamped once between the
  // most negative bucket value and the configured ceiling.
  always_comb begin
    ceiling   = $signed({3'b000, cfg_burst_i, {FRAC_BITS{1'b0}}});
    floor_val = $signed({3'b111, {(BW-1){1'b0}}});
    cost      = '0;
    if (beat) begin
      cost = $signed({{(SW-KCW-FRAC_BITS){1'b0}}, keep_count, {FRAC_BITS{1'b0}}});
    end
    sum         = $signed({{2{bucket[BW-1]}}, bucket}) + $signed({3'b000, cfg_rate_i}) - cost;
    bucket_next = sum[BW-1:0];
    if (sum > ceiling) begin
      bucket_next = ceiling[BW-1:0];
    end else if (sum < floor_val) begin
      bucket_next = floor_val[BW-1:0];
    end
  end

  // Packet framing FSM, bucket register and statistics counters. In bypass the
  // bucket is pinned full so re-enabling starts with a full burst allowance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      bucket      <= '0;
      pkt_cnt_o   <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (beat) begin
        state <= s_axis.tlast ? IDLE : PASS;
      end
      bucket <= cfg_enable_i ? bucket_next : ceiling[BW-1:0];
      if (beat & s_axis.tlast) begin
        pkt_cnt_o <= pkt_cnt_o + 32'd1;
      end
      if (s_axis.tvalid & ~allow) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
    end
  end

endmodule
